// File: rtl/dcmi_pkg.sv
// dcmi_pkg: width/decimation codes and byte-count helper for the DCMI packer
package dcmi_pkg;
  localparam int PIX_W = 14;
  typedef enum logic [1:0] {DW_8, DW_10, DW_12, DW_14} dw_e;
  typedef enum logic [1:0] {SEL_ALL, SEL_1OF2, SEL_1OF4, SEL_2OF4} sel_e;
  function automatic logic [7:0] bcnt_of(input logic [7:0] k, input logic [1:0] dw);
    return dw == DW_8 ? k : {k[6:0], 1'b0};
  endfunction
endpackage

// File: rtl/dcmi_pack_fifo_if.sv
// dcmi_pack_fifo_if: packed-word valid/ready output bus
interface dcmi_pack_fifo_if #(parameter int OUT_W = 32);
  localparam int BW = $clog2(OUT_W / 8) + 1;
  logic out_vld;
  logic out_rdy;
  logic out_last;
  logic [OUT_W-1:0] out_data;
  logic [BW-1:0] out_bcnt;
  modport master(output out_vld, out_data, out_last, out_bcnt, input out_rdy);
  modport slave(input out_vld, out_data, out_last, out_bcnt, output out_rdy);
endinterface

// File: rtl/dcmi_sfifo.sv
// dcmi_sfifo: synchronous FIFO with simultaneous push/pop and occupancy level
module dcmi_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic pclk,
  input  logic rstn,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge pclk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(rd);
    end
  always_ff @(posedge pclk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/dcmi_pack_fifo.sv
// dcmi_pack_fifo: decimates and packs DCMI pixels into words, buffered in a FIFO
module dcmi_pack_fifo
  import dcmi_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic pclk,
  input  logic rstn,
  input  logic clr,
  input  logic enable,
  input  logic [1:0] data_bus_width,
  input  logic [1:0] byte_sel_mode,
  input  logic byte_sel_start,
  input  logic pix_vld,
  input  logic [PIX_W-1:0] pix_data,
  input  logic line_start,
  input  logic frame_end,
  dcmi_pack_fifo_if.master bus,
  output logic [AW:0] level,
  output logic ovfl_pulse
);
  localparam int BW = $clog2(OUT_W / 8) + 1;
  localparam int FW = OUT_W + BW + 1;
  logic [1:0] phase, ph;
  logic [OUT_W-1:0] sr, ins, wd;
  logic [BW-1:0] cnt, cnt_n, nslots, bcnt;
  logic pv, keep, kept, fe, full_word, push, pop, full, empty;
  logic [FW-1:0] dout;
  always_comb begin
    pv = enable && pix_vld;
    fe = enable && frame_end;
    ph = (enable && line_start) ? 2'd0 : phase;
    keep = byte_sel_mode == SEL_ALL  ? 1'b1 :
           byte_sel_mode == SEL_1OF2 ? ph[0] == byte_sel_start :
           byte_sel_mode == SEL_1OF4 ? ph == {byte_sel_start, 1'b0} :
                                       ph[1] == byte_sel_start;
    kept = pv && keep;
    ins = data_bus_width == DW_8 ? sr | (OUT_W'(pix_data[7:0]) << {cnt, 3'b0})
                                 : sr | (OUT_W'(pix_data) << {cnt, 4'b0});
    nslots = data_bus_width == DW_8 ? BW'(OUT_W / 8) : BW'(OUT_W / 16);
    cnt_n = cnt + BW'(kept);
    wd = kept ? ins : sr;
    full_word = kept && cnt_n == nslots;
    bcnt = BW'(bcnt_of(8'(cnt_n), data_bus_width));
    push = !clr && (full_word || fe);
    pop = bus.out_vld && bus.out_rdy;
    ovfl_pulse = push && full && !pop;
  end
  always_ff @(posedge pclk or negedge rstn)
    if (!rstn) begin
      phase <= '0;
      sr <= '0;
      cnt <= '0;
    end else begin
      phase <= (clr || fe) ? 2'd0 : pv ? ph + 2'd1 : ph;
      sr <= (clr || push) ? '0 : wd;
      cnt <= (clr || push) ? '0 : cnt_n;
    end
  dcmi_sfifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .pclk(pclk),
    .rstn(rstn),
    .clr(clr),
    .push(push),
    .pop(pop),
    .din({fe, bcnt, wd}),
    .dout(dout),
    .empty(empty),
    .full(full),
    .level(level)
  );
  assign bus.out_vld = !empty;
  assign {bus.out_last, bus.out_bcnt, bus.out_data} = dout;
endmodule

// File: tb/tb_dcmi_pack_fifo.sv
// tb_dcmi_pack_fifo: directed checks of packing, decimation, flush, overflow and reset
module tb_dcmi_pack_fifo;
  logic pclk = 0, rstn = 0, clr = 0, enable = 0;
  logic [1:0] data_bus_width = 2'd0, byte_sel_mode = 2'd0;
  logic byte_sel_start = 0, pix_vld = 0, line_start = 0, frame_end = 0;
  logic [13:0] pix_data = '0;
  logic [3:0] level;
  logic ovfl_pulse;
  int n_chk = 0, n_fail = 0, n_ovfl = 0;
  dcmi_pack_fifo_if #(.OUT_W(32)) bus ();
  dcmi_pack_fifo #(.OUT_W(32), .DEPTH(8)) dut (
    .pclk(pclk), .rstn(rstn), .clr(clr), .enable(enable),
    .data_bus_width(data_bus_width), .byte_sel_mode(byte_sel_mode),
    .byte_sel_start(byte_sel_start), .pix_vld(pix_vld), .pix_data(pix_data),
    .line_start(line_start), .frame_end(frame_end), .bus(bus),
    .level(level), .ovfl_pulse(ovfl_pulse)
  );
  always #5 pclk = ~pclk;
  task automatic step();
    #1 n_ovfl += int'(ovfl_pulse);
    @(negedge pclk);
  endtask
  task automatic send(input logic [13:0] d);
    pix_vld = 1;
    pix_data = d;
    step();
    pix_vld = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reconf(input logic [1:0] dw, input logic [1:0] mode, input logic st);
    enable = 0;
    data_bus_width = dw;
    byte_sel_mode = mode;
    byte_sel_start = st;
    clr = 1;
    step();
    clr = 0;
    enable = 1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, 32'(bus.out_vld), 32'd0);
    chk({tag, "_data"}, bus.out_data, 32'd0);
    chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_bcnt"}, 32'(bus.out_bcnt), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_ovfl"}, 32'(ovfl_pulse), 32'd0);
  endtask
  initial begin
    bus.out_rdy = 1;
    @(negedge pclk);
    chk_zero("rst");
    rstn = 1;
    step();
    reconf(2'd0, 2'd0, 1'b0);
    send(14'h11); send(14'h22); send(14'h33); send(14'h44);
    chk("w8_vld", 32'(bus.out_vld), 32'd1);
    chk("w8_data", bus.out_data, 32'h44332211);
    chk("w8_bcnt", 32'(bus.out_bcnt), 32'd4);
    chk("w8_last", 32'(bus.out_last), 32'd0);
    chk("w8_level", 32'(level), 32'd1);
    step();
    chk("w8_drain", 32'(level), 32'd0);
    reconf(2'd2, 2'd0, 1'b0);
    send(14'hABC); send(14'h123);
    chk("w12_data", bus.out_data, 32'h01230ABC);
    chk("w12_bcnt", 32'(bus.out_bcnt), 32'd4);
    step();
    reconf(2'd0, 2'd1, 1'b1);
    line_start = 1; step(); line_start = 0;
    for (int i = 0; i < 8; i++) send(14'(i));
    chk("sel1of2", bus.out_data, 32'h07050301);
    step();
    reconf(2'd0, 2'd3, 1'b1);
    line_start = 1; step(); line_start = 0;
    for (int i = 0; i < 8; i++) send(14'(i));
    chk("sel2of4", bus.out_data, 32'h07060302);
    step();
    reconf(2'd0, 2'd0, 1'b0);
    send(14'h11); send(14'h22); send(14'h33);
    frame_end = 1; step(); frame_end = 0;
    chk("flush_data", bus.out_data, 32'h00332211);
    chk("flush_bcnt", 32'(bus.out_bcnt), 32'd3);
    chk("flush_last", 32'(bus.out_last), 32'd1);
    step();
    frame_end = 1; step(); frame_end = 0;
    chk("marker_vld", 32'(bus.out_vld), 32'd1);
    chk("marker_data", bus.out_data, 32'd0);
    chk("marker_bcnt", 32'(bus.out_bcnt), 32'd0);
    chk("marker_last", 32'(bus.out_last), 32'd1);
    step();
    chk("marker_pop", 32'(bus.out_vld), 32'd0);
    bus.out_rdy = 0;
    n_ovfl = 0;
    for (int i = 0; i < 36; i++) send(14'(i));
    chk("full_level", 32'(level), 32'd8);
    chk("full_ovfl", 32'(n_ovfl), 32'd1);
    chk("full_head", bus.out_data, 32'h03020100);
    n_ovfl = 0;
    bus.out_rdy = 1;
    frame_end = 1;
    step();
    chk("pp_head", bus.out_data, 32'h07060504);
    chk("pp_level0", 32'(level), 32'd8);
    repeat (4) step();
    frame_end = 0;
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovfl", 32'(n_ovfl), 32'd0);
    step();
    chk("pp_after", 32'(level), 32'd7);
    for (int k = 0; k < 20 && bus.out_vld; k++) step();
    chk("drain", 32'(bus.out_vld), 32'd0);
    bus.out_rdy = 0;
    for (int i = 0; i < 14; i++) send(14'(8'h40 + i));
    chk("pre_rst_level", 32'(level), 32'd3);
    rstn = 0;
    #1;
    chk_zero("midrst");
    @(negedge pclk);
    rstn = 1;
    step();
    send(14'hA1); send(14'hA2); send(14'hA3); send(14'hA4);
    chk("post_rst_level", 32'(level), 32'd1);
    chk("post_rst_data", bus.out_data, 32'hA4A3A2A1);
    chk("post_rst_bcnt", 32'(bus.out_bcnt), 32'd4);
    chk("post_rst_last", 32'(bus.out_last), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
